// File: rtl/layer_init_data_sender.sv
// rtl/layer_init_data_sender.sv - packs a float16 stream into fm vectors and weight slices for layer init-load
// Optional stall counter output is enabled by defining INIT_SENDER_STALL_CNT_EN.
module layer_init_data_sender #(
  parameter int DATA_WIDTH              = 16,
  parameter int PARA_X                  = 3,
  parameter int PARA_Y                  = 3,
  parameter int PARA_KERNEL             = 2,
  parameter int KERNEL_SIZE_MAX         = 5,
  parameter int KERNEL_SIZE_WIDTH       = 6,
  parameter int WRITE_ADDR_WIDTH        = 3,
  parameter int WEIGHT_WRITE_ADDR_WIDTH = 5,
  parameter int HOLD_CYCLES             = 2
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic [1:0]                                                    layer_type,
  input  logic                                                          start,
  input  logic [KERNEL_SIZE_WIDTH-1:0]                                  kernel_size,
  input  logic [WRITE_ADDR_WIDTH:0]                                     fm_vec_count,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH:0]                              wt_slice_count,
  input  logic [DATA_WIDTH-1:0]                                         in_data,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]                           init_fm_data,
  output logic [WRITE_ADDR_WIDTH-1:0]                                   write_fm_data_addr,
  output logic                                                          init_fm_data_done,
  output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data,
  output logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                write_weight_data_addr,
  output logic                                                          weight_data_done,
  input  logic                                                          init_fm_ram_ready,
  input  logic                                                          init_weight_ram_ready,
  output logic                                                          busy,
  output logic                                                          load_done,
  output logic                                                          err
`ifdef INIT_SENDER_STALL_CNT_EN
  ,
  output logic [15:0]                                                   stall_count
`endif
);

  localparam int FM_WORDS = PARA_X * PARA_Y;
  localparam int FM_W     = FM_WORDS * DATA_WIDTH;
  localparam int KSQ_MAX  = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int WT_W     = KSQ_MAX * PARA_KERNEL * DATA_WIDTH;
  localparam int IDX_W    = (FM_WORDS > 1) ? $clog2(FM_WORDS) : 1;
  localparam int KSQ_W    = 2 * KERNEL_SIZE_WIDTH;
  localparam int K_W      = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);

  localparam logic [IDX_W-1:0]                   FM_LAST    = IDX_W'(FM_WORDS - 1);
  localparam logic [K_W-1:0]                     K_LAST     = K_W'(PARA_KERNEL - 1);
  localparam logic [HOLD_W-1:0]                  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [KERNEL_SIZE_WIDTH-1:0]       KS_MAX     = KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX);
  localparam logic [WRITE_ADDR_WIDTH:0]          FM_CNT_MAX = {1'b1, {WRITE_ADDR_WIDTH{1'b0}}};
  localparam logic [WEIGHT_WRITE_ADDR_WIDTH:0]   WT_CNT_MAX = {1'b1, {WEIGHT_WRITE_ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FM_FILL, S_FM_HOLD, S_FM_WAIT, S_WT_FILL, S_WT_HOLD, S_WT_WAIT
  } state_t;

  state_t                                  r_state;
  logic                                    r_in_ready;
  logic                                    r_busy;
  logic                                    r_load_done;
  logic                                    r_err;
  logic                                    r_fm_done;
  logic                                    r_wt_done;
  logic [FM_W-1:0]                         r_fm_stage;
  logic [FM_W-1:0]                         r_fm_data;
  logic [WRITE_ADDR_WIDTH-1:0]             r_fm_addr;
  logic [WT_W-1:0]                         r_wt_stage;
  logic [WT_W-1:0]                         r_wt_data;
  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0] r_wt_addr;
  logic [IDX_W-1:0]                        r_fm_idx;
  logic [KSQ_W-1:0]                        r_wt_p;
  logic [K_W-1:0]                          r_wt_k;
  logic [HOLD_W-1:0]                       r_hold;
  logic [WRITE_ADDR_WIDTH:0]               r_fm_cnt;
  logic [WRITE_ADDR_WIDTH:0]               r_fm_total;
  logic [WEIGHT_WRITE_ADDR_WIDTH:0]        r_wt_cnt;
  logic [WEIGHT_WRITE_ADDR_WIDTH:0]        r_wt_total;
  logic [KSQ_W-1:0]                        r_ks_sq;

  logic                                    w_cfg_ok;
  logic                                    w_start_ok;
  logic [KSQ_W-1:0]                        w_ks_sq;
  logic [FM_W-1:0]                         w_fm_stage;
  logic [WT_W-1:0]                         w_wt_stage;

  assign w_cfg_ok   = (kernel_size != '0) && (kernel_size <= KS_MAX) &&
                      (fm_vec_count <= FM_CNT_MAX) && (wt_slice_count <= WT_CNT_MAX);
  assign w_start_ok = (r_state == S_IDLE) && start && (layer_type == 2'd0) && w_cfg_ok;
  assign w_ks_sq    = kernel_size * kernel_size;

  // Staging with the incoming word merged in, so the final word can go straight to the outputs.
  always_comb begin
    w_fm_stage = r_fm_stage;
    w_fm_stage[r_fm_idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
    w_wt_stage = r_wt_stage;
    w_wt_stage[(int'(r_wt_k)*KSQ_MAX + int'(r_wt_p))*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_fm_done   <= 1'b0;
      r_wt_done   <= 1'b0;
      r_fm_stage  <= '0;
      r_fm_data   <= '0;
      r_fm_addr   <= '0;
      r_wt_stage  <= '0;
      r_wt_data   <= '0;
      r_wt_addr   <= '0;
      r_fm_idx    <= '0;
      r_wt_p      <= '0;
      r_wt_k      <= '0;
      r_hold      <= '0;
      r_fm_cnt    <= '0;
      r_fm_total  <= '0;
      r_wt_cnt    <= '0;
      r_wt_total  <= '0;
      r_ks_sq     <= '0;
    end else begin
      r_err       <= 1'b0;
      r_load_done <= 1'b0;
      if (r_state != S_IDLE && layer_type != 2'd0) begin
        r_err      <= 1'b1;
        r_busy     <= 1'b0;
        r_in_ready <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && layer_type == 2'd0) begin
              if (w_cfg_ok) begin
                r_busy     <= 1'b1;
                r_fm_done  <= 1'b0;
                r_wt_done  <= 1'b0;
                r_fm_total <= fm_vec_count;
                r_wt_total <= wt_slice_count;
                r_ks_sq    <= w_ks_sq;
                r_fm_cnt   <= '0;
                r_wt_cnt   <= '0;
                r_fm_addr  <= '0;
                r_wt_addr  <= '0;
                r_fm_idx   <= '0;
                r_wt_p     <= '0;
                r_wt_k     <= '0;
                r_wt_stage <= '0;
                if (fm_vec_count == '0) begin
                  r_fm_done <= 1'b1;
                  r_state   <= S_FM_WAIT;
                end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= S_FM_FILL;
                end
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_FM_FILL: begin
            if (in_valid) begin
              r_fm_stage <= w_fm_stage;
              if (r_fm_idx == FM_LAST) begin
                r_fm_idx   <= '0;
                r_fm_data  <= w_fm_stage;
                r_fm_addr  <= r_fm_cnt[WRITE_ADDR_WIDTH-1:0];
                r_in_ready <= 1'b0;
                r_hold     <= '0;
                r_state    <= S_FM_HOLD;
              end else begin
                r_fm_idx <= r_fm_idx + 1'b1;
              end
            end
          end
          S_FM_HOLD: begin
            if (r_hold == HOLD_LAST) begin
              r_fm_cnt <= r_fm_cnt + 1'b1;
              if ((r_fm_cnt + 1'b1) == r_fm_total) begin
                r_fm_done <= 1'b1;
                r_state   <= S_FM_WAIT;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= S_FM_FILL;
              end
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          S_FM_WAIT: begin
            if (init_fm_ram_ready) begin
              if (r_wt_total == '0) begin
                r_wt_done <= 1'b1;
                r_state   <= S_WT_WAIT;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= S_WT_FILL;
              end
            end
          end
          S_WT_FILL: begin
            if (in_valid) begin
              r_wt_stage <= w_wt_stage;
              if ((r_wt_p + 1'b1) == r_ks_sq) begin
                r_wt_p <= '0;
                if (r_wt_k == K_LAST) begin
                  r_wt_k     <= '0;
                  r_wt_data  <= w_wt_stage;
                  r_wt_addr  <= {PARA_KERNEL{r_wt_cnt[WEIGHT_WRITE_ADDR_WIDTH-1:0]}};
                  r_in_ready <= 1'b0;
                  r_hold     <= '0;
                  r_state    <= S_WT_HOLD;
                end else begin
                  r_wt_k <= r_wt_k + 1'b1;
                end
              end else begin
                r_wt_p <= r_wt_p + 1'b1;
              end
            end
          end
          S_WT_HOLD: begin
            if (r_hold == HOLD_LAST) begin
              r_wt_cnt <= r_wt_cnt + 1'b1;
              if ((r_wt_cnt + 1'b1) == r_wt_total) begin
                r_wt_done <= 1'b1;
                r_state   <= S_WT_WAIT;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= S_WT_FILL;
              end
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          S_WT_WAIT: begin
            if (init_weight_ram_ready) begin
              r_load_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef INIT_SENDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // r_in_ready is high exactly in the two FILL states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (r_in_ready && !in_valid && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

  assign in_ready               = r_in_ready;
  assign init_fm_data           = r_fm_data;
  assign write_fm_data_addr     = r_fm_addr;
  assign init_fm_data_done      = r_fm_done;
  assign weight_data            = r_wt_data;
  assign write_weight_data_addr = r_wt_addr;
  assign weight_data_done       = r_wt_done;
  assign busy                   = r_busy;
  assign load_done              = r_load_done;
  assign err                    = r_err;

endmodule

// File: doc/layer_init_data_sender.md
Name: layer_init_data_sender

Overview:
- Producer side of the layer init-load interface.
- Accepts a 16-bit float16 word stream, packs it into feature-map vectors (PARA_X*PARA_Y words) and weight slices (PARA_KERNEL kernels of kernel_size² words).
- Drives the layer's fm/weight write data, address and done signals, then waits for the layer's RAM-ready handshakes.
- Sits between the DMA/stream front end and the layer controller while layer_type==0.

Parameters:
- DATA_WIDTH, 16, float16 word width
- PARA_X, 3, fm RAM count (MAC groups)
- PARA_Y, 3, words per fm RAM entry
- PARA_KERNEL, 2, parallel kernels
- KERNEL_SIZE_MAX, 5, max kernel edge
- KERNEL_SIZE_WIDTH, 6, kernel_size width
- WRITE_ADDR_WIDTH, 3, fm write address width
- WEIGHT_WRITE_ADDR_WIDTH, 5, weight write address width per kernel
- HOLD_CYCLES, 2, cycles each packed write is held stable (min 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- layer_type  in  2  layer mode; the sender operates only when 0
- start  in  1  one-cycle pulse that begins a load
- kernel_size  in  KERNEL_SIZE_WIDTH  weight slice edge, valid range 1..KERNEL_SIZE_MAX
- fm_vec_count  in  WRITE_ADDR_WIDTH+1  fm vectors to send, 0..2^WRITE_ADDR_WIDTH
- wt_slice_count  in  WEIGHT_WRITE_ADDR_WIDTH+1  weight slices to send, 0..2^WEIGHT_WRITE_ADDR_WIDTH
- in_data  in  DATA_WIDTH  stream word
- in_valid  in  1  stream valid
- in_ready  out  1  stream ready
- init_fm_data  out  PARA_X*PARA_Y*DATA_WIDTH  packed fm vector
- write_fm_data_addr  out  WRITE_ADDR_WIDTH  fm write address
- init_fm_data_done  out  1  fm transfer complete
- weight_data  out  KERNEL_SIZE_MAX²*PARA_KERNEL*DATA_WIDTH  packed weight slice
- write_weight_data_addr  out  WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL  weight address, replicated per kernel lane
- weight_data_done  out  1  weight transfer complete
- init_fm_ram_ready  in  1  layer fm RAM loaded
- init_weight_ram_ready  in  1  layer weight RAM loaded
- busy  out  1  load in progress
- load_done  out  1  one-cycle pulse when both RAMs report ready
- err  out  1  one-cycle pulse on rejected start or abort

Behaviour:
- Reset values: all outputs are 0, and the FSM is in IDLE.
- States: IDLE, FM_FILL, FM_HOLD, FM_WAIT, WT_FILL, WT_HOLD, WT_WAIT.
- IDLE:
  - start with layer_type==0 and all three config inputs in range: latch the config, set busy=1, clear both done flags, zero both address counters, go to FM_FILL.
  - start with any config value out of range (kernel_size==0 or >KERNEL_SIZE_MAX; fm_vec_count or wt_slice_count above max): err pulse, stay IDLE.
  - start while busy is ignored, with no err.
- FM_FILL:
  - in_ready=1. Each handshake stores word i (i = x*PARA_Y + y) into a staging register at bits [16i+15:16i].
  - When the final word (i = PARA_X*PARA_Y-1) is accepted, init_fm_data and write_fm_data_addr update together on the next edge, and the FSM enters FM_HOLD.
- FM_HOLD:
  - in_ready=0; outputs stay stable for HOLD_CYCLES cycles, then the address increments.
  - Return to FM_FILL, or go to FM_WAIT after vector fm_vec_count-1.
  - Address wraps modulo 2^WRITE_ADDR_WIDTH (never reached when inputs are in range).
- FM_WAIT:
  - init_fm_data_done=1 from entry onward; it stays 1 until the next accepted start or reset.
  - When init_fm_ram_ready==1, go to WT_FILL.
  - fm_vec_count==0 goes from IDLE straight to FM_WAIT.
- Stable outputs during fill: while filling, the previous packed data/address remain on the outputs. The layer rewrites the same entry harmlessly.
- WT_FILL:
  - Accepts PARA_KERNEL*kernel_size² words, kernel-major. Word p of kernel k goes to bits [(k*KERNEL_SIZE_MAX²+p)*16 +: 16].
  - Positions p ≥ kernel_size² are driven 0.
- WT_HOLD: same hold rule as FM_HOLD; the weight address increments per slice.
- WT_WAIT:
  - weight_data_done=1 and held until the next accepted start or reset.
  - When init_weight_ram_ready==1: load_done pulse, busy=0, go to IDLE.
  - wt_slice_count==0 skips directly to WT_WAIT.
- Abort: if layer_type≠0 in any non-IDLE state, err pulse, go to IDLE, busy=0. Done flags keep their values; staging is discarded.
- Simultaneous events: in_valid is ignored outside FILL states. A ready input that is already 1 on entry to a WAIT state is honoured in that same cycle's transition.
- Async reset mid-load: all outputs return to 0 immediately; any partial vector is lost.

Optional Feature:
- Macro: INIT_SENDER_STALL_CNT_EN
- With the macro defined:
  - Adds output stall_count (16 bits).
  - Counts cycles in FM_FILL/WT_FILL with in_valid==0. Saturates at 0xFFFF.
  - Cleared on reset and on accepted start.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic fm load:
  - Stimulus: fm_vec_count=2, wt_slice_count=0, 18 words 0x3C00+n with in_valid continuously high, ram-ready responses tied high.
  - Required: addr0 holds words 0..8 packed LSB-first; addr1 holds words 9..17; init_fm_data_done rises after the 2nd hold; load_done pulses once.
- Weight padding:
  - Stimulus: kernel_size=3, wt_slice_count=1, 18 words.
  - Required: kernel0 bits 0..143 hold words 0..8; kernel1 starts at bit 400; bits 144..399 are zero; write_weight_data_addr=10'h000.
- Invalid config:
  - Stimulus: start with kernel_size=6, and separately fm_vec_count=9.
  - Required: err pulse, busy stays 0, outputs unchanged.
- Stalls:
  - Stimulus: in_valid toggled 1/0 during fill.
  - Required: packing order is unchanged; the stall counter (if enabled) equals the number of idle cycles.
- Handshake wait:
  - Stimulus: init_fm_ram_ready held 0 for 10 cycles.
  - Required: FSM stays in FM_WAIT, in_ready=0; weight fill starts the cycle after ready rises.
- Abort and reset:
  - Stimulus: layer_type=1 mid FM_FILL, then rst low mid WT_FILL.
  - Required: err pulse and IDLE; after the reset, all outputs are 0.
